// File: rtl/target_generator.sv
// target_generator: LFSR-driven target source for the guess/compare game with round, score and timeout tracking
module target_generator #(
    parameter logic [7:0] SEED       = 8'hA5,
    parameter int         TIMEOUT    = 20,
    parameter int         MAX_ROUNDS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] guess,
    input  logic       guess_valid,
    output logic [3:0] target,
    output logic       target_valid,
    output logic       hit,
    output logic       miss,
    output logic       timeout,
    output logic [3:0] score,
    output logic [3:0] round,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT, SCORE, DONE} state_t;

    // A zero seed would lock the LFSR, so it is replaced by 1
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] TMAX     = 8'(TIMEOUT - 1);
    localparam logic [3:0] RMAX     = 4'(MAX_ROUNDS);

    state_t     state;
    logic [7:0] lfsr;
    logic [7:0] timer;
    logic [7:0] lfsr_next;
    logic [3:0] round_next;
    logic       match;
    logic       expired;

    assign lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign round_next = round + 4'd1;
    assign match      = guess_valid && (guess == target);
    assign expired    = (timer == TMAX);

    // Game FSM; every output is a register updated alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            lfsr         <= SEED_EFF;
            target       <= 4'd0;
            timer        <= 8'd0;
            score        <= 4'd0;
            round        <= 4'd0;
            target_valid <= 1'b0;
            hit          <= 1'b0;
            miss         <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            hit     <= 1'b0;
            miss    <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= LOAD;
                        score <= 4'd0;
                        round <= 4'd0;
                        timer <= 8'd0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                LOAD: begin
                    lfsr         <= lfsr_next;
                    target       <= lfsr_next[3:0];
                    timer        <= 8'd0;
                    target_valid <= 1'b1;
                    state        <= WAIT;
                end
                WAIT: begin
                    // A hit on the final cycle beats the timeout; a miss there is swallowed by the timeout
                    if (match) begin
                        hit          <= 1'b1;
                        score        <= score + 4'd1;
                        target_valid <= 1'b0;
                        state        <= SCORE;
                    end else if (expired) begin
                        timeout      <= 1'b1;
                        target_valid <= 1'b0;
                        state        <= SCORE;
                    end else begin
                        miss  <= guess_valid;
                        timer <= timer + 8'd1;
                    end
                end
                SCORE: begin
                    round <= round_next;
                    if (round_next == RMAX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_target_generator.sv
// tb_target_generator: directed checks of target sequence, hit/miss/timeout pulses, game end and async reset
module tb_target_generator;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] guess = 4'd0;
    logic       guess_valid = 1'b0;
    logic [3:0] target;
    logic       target_valid;
    logic       hit;
    logic       miss;
    logic       timeout;
    logic [3:0] score;
    logic [3:0] round;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Hand-derived target sequence from SEED=A5
    logic [3:0] seq [0:11] = '{4'hA, 4'h5, 4'hA, 4'h4, 4'h9, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7, 4'hE};

    target_generator dut (
        .clk(clk), .reset(reset), .start(start), .guess(guess), .guess_valid(guess_valid),
        .target(target), .target_valid(target_valid), .hit(hit), .miss(miss), .timeout(timeout),
        .score(score), .round(round), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        guess_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start_game();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!target_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!target_valid) begin
            errors++;
            $display("FAIL %s: target_valid never rose within 50 cycles", name);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({target, target_valid, hit, miss, timeout, score, round, busy, done} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected 0",
                     {target, target_valid, hit, miss, timeout, score, round, busy, done});
        end
        @(negedge clk);
        reset = 1'b0;
        start_game();
        checks++;
        if (target_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_state: target_valid=%b busy=%b, expected 0 1", target_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (target_valid !== 1'b1 || target !== 4'hA) begin
            errors++;
            $display("FAIL first_target: valid=%b target=%h, expected 1 a", target_valid, target);
        end
    endtask

    task automatic test_timeout_rounds();
        do_reset();
        start_game();
        for (int r = 0; r < 3; r++) begin
            int n = 0;
            wait_valid("timeout_round_valid");
            checks++;
            if (target !== seq[r]) begin
                errors++;
                $display("FAIL timeout_target[%0d]: got %h, expected %h", r, target, seq[r]);
            end
            while (!timeout && n < 40) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n !== 20) begin
                errors++;
                $display("FAIL timeout_delay[%0d]: got %0d cycles, expected 20", r, n);
            end
            checks++;
            if (score !== 4'd0 || hit !== 1'b0) begin
                errors++;
                $display("FAIL timeout_score[%0d]: score=%0d hit=%b, expected 0 0", r, score, hit);
            end
            @(negedge clk);
            checks++;
            if (timeout !== 1'b0 || round !== 4'(r + 1)) begin
                errors++;
                $display("FAIL timeout_round[%0d]: timeout=%b round=%0d, expected 0 %0d", r, timeout, round, r + 1);
            end
        end
    endtask

    task automatic test_hit();
        do_reset();
        start_game();
        wait_valid("hit_valid");
        @(negedge clk);
        @(negedge clk);
        guess = 4'hA;
        guess_valid = 1'b1;
        @(negedge clk);
        guess_valid = 1'b0;
        checks++;
        if (hit !== 1'b1 || miss !== 1'b0 || timeout !== 1'b0 || score !== 4'd1) begin
            errors++;
            $display("FAIL hit_pulse: hit=%b miss=%b timeout=%b score=%0d, expected 1 0 0 1", hit, miss, timeout, score);
        end
        @(negedge clk);
        checks++;
        if (hit !== 1'b0 || round !== 4'd1) begin
            errors++;
            $display("FAIL hit_round: hit=%b round=%0d, expected 0 1", hit, round);
        end
        wait_valid("hit_next_valid");
        checks++;
        if (target !== 4'h5) begin
            errors++;
            $display("FAIL hit_next_target: got %h, expected 5", target);
        end
    endtask

    task automatic test_miss_then_hit();
        do_reset();
        start_game();
        wait_valid("miss_valid");
        guess = 4'h3;
        guess_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (miss !== 1'b1 || hit !== 1'b0 || target_valid !== 1'b1) begin
            errors++;
            $display("FAIL miss_pulse: miss=%b hit=%b valid=%b, expected 1 0 1", miss, hit, target_valid);
        end
        guess = 4'hA;
        @(negedge clk);
        guess_valid = 1'b0;
        checks++;
        if (miss !== 1'b0 || hit !== 1'b1 || score !== 4'd1) begin
            errors++;
            $display("FAIL miss_then_hit: miss=%b hit=%b score=%0d, expected 0 1 1", miss, hit, score);
        end
        @(negedge clk);
        checks++;
        if (round !== 4'd1 || miss !== 1'b0) begin
            errors++;
            $display("FAIL miss_round: round=%0d miss=%b, expected 1 0", round, miss);
        end
    endtask

    task automatic test_timeout_edge();
        do_reset();
        start_game();
        wait_valid("edge_valid");
        for (int i = 0; i < 19; i++) @(negedge clk);
        guess = 4'hA;
        guess_valid = 1'b1;
        @(negedge clk);
        guess_valid = 1'b0;
        checks++;
        if (hit !== 1'b1 || timeout !== 1'b0 || score !== 4'd1) begin
            errors++;
            $display("FAIL edge_hit: hit=%b timeout=%b score=%0d, expected 1 0 1", hit, timeout, score);
        end
        @(negedge clk);
        checks++;
        if (timeout !== 1'b0 || round !== 4'd1) begin
            errors++;
            $display("FAIL edge_after: timeout=%b round=%0d, expected 0 1", timeout, round);
        end
    endtask

    task automatic test_full_game();
        int n = 0;
        do_reset();
        start_game();
        for (int r = 0; r < 10; r++) begin
            wait_valid("game_valid");
            checks++;
            if (target !== seq[r]) begin
                errors++;
                $display("FAIL game_target[%0d]: got %h, expected %h", r, target, seq[r]);
            end
            guess = seq[r];
            guess_valid = 1'b1;
            @(negedge clk);
            guess_valid = 1'b0;
            checks++;
            if (hit !== 1'b1) begin
                errors++;
                $display("FAIL game_hit[%0d]: hit=%b, expected 1", r, hit);
            end
        end
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1 || score !== 4'hA || round !== 4'hA || busy !== 1'b0 || target_valid !== 1'b0 || target !== 4'hB) begin
            errors++;
            $display("FAIL game_done: done=%b score=%0d round=%0d busy=%b valid=%b target=%h, expected 1 10 10 0 0 b",
                     done, score, round, busy, target_valid, target);
        end
        guess = 4'hB;
        guess_valid = 1'b1;
        @(negedge clk);
        guess_valid = 1'b0;
        checks++;
        if (hit !== 1'b0 || miss !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_guess_ignored: hit=%b miss=%b done=%b, expected 0 0 1", hit, miss, done);
        end
        start_game();
        checks++;
        if (score !== 4'd0 || round !== 4'd0 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart: score=%0d round=%0d done=%b busy=%b, expected 0 0 0 1", score, round, done, busy);
        end
        @(negedge clk);
        checks++;
        if (target_valid !== 1'b1 || target !== seq[10]) begin
            errors++;
            $display("FAIL restart_target: valid=%b target=%h, expected 1 %h", target_valid, target, seq[10]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        start_game();
        wait_valid("async_valid");
        guess = 4'hA;
        guess_valid = 1'b1;
        @(negedge clk);
        guess_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (hit !== 1'b0 || score !== 4'd0 || busy !== 1'b0 || target !== 4'd0) begin
            errors++;
            $display("FAIL async_pulse_clear: hit=%b score=%0d busy=%b target=%h, expected 0 0 0 0", hit, score, busy, target);
        end
        @(negedge clk);
        reset = 1'b0;
        start_game();
        wait_valid("async_valid2");
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (target_valid !== 1'b0 || busy !== 1'b0 || target !== 4'd0 || round !== 4'd0) begin
            errors++;
            $display("FAIL async_wait_clear: valid=%b busy=%b target=%h round=%0d, expected 0 0 0 0", target_valid, busy, target, round);
        end
        @(negedge clk);
        reset = 1'b0;
        guess = 4'd0;
        guess_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (hit !== 1'b0 || miss !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_guess[%0d]: hit=%b miss=%b busy=%b, expected 0 0 0", i, hit, miss, busy);
            end
        end
        guess_valid = 1'b0;
        start_game();
        @(negedge clk);
        checks++;
        if (target_valid !== 1'b1 || target !== 4'hA) begin
            errors++;
            $display("FAIL reseed_target: valid=%b target=%h, expected 1 a", target_valid, target);
        end
    endtask

    initial begin
        test_reset();
        test_timeout_rounds();
        test_hit();
        test_miss_then_hit();
        test_timeout_edge();
        test_full_game();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
